frame_buffer_writer: RTL and testbench

FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

---
 rtl/frame_buffer_writer_if.sv | 15 +
 rtl/frame_buffer_writer.sv | 186 ++++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_writer_if.sv
// Pixel stream handshake between the draw engine and the framebuffer writer.
//   pix_valid : the pixel on x_in/y_in is valid
//   x_in      : signed 9-bit pixel x
//   y_in      : signed 8-bit pixel y
//   pix_ready : writer can take a pixel this cycle
// master = draw engine side, slave = framebuffer writer side.
interface frame_buffer_writer_if;
   logic       pix_valid;
   logic [8:0] x_in;
   logic [7:0] y_in;
   logic       pix_ready;

   modport master (output pix_valid, x_in, y_in, input pix_ready);
   modport slave  (input pix_valid, x_in, y_in, output pix_ready);
endinterface

// File: rtl/frame_buffer_writer.sv
// 1-bit-per-pixel framebuffer writer with clipping, a 2-stage
// read-modify-write plot pipeline, a sequenced clear and a registered
// scanout read port.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   pix        pixel stream (slave modport of frame_buffer_writer_if)
//   clear_req  request a framebuffer clear (honoured only in RUN)
//   busy       high during DRAIN and CLEAR
//   rd_addr    scanout word address
//   rd_data    scanout word, 1-cycle latency; holds on out-of-range address
//   plot_cnt   pixels written since last clear (saturating)
//   clip_cnt   pixels dropped by clipping since last clear (saturating)
//
// Build option: define FB_CLIP_COUNT_EN to implement clip_cnt; otherwise
// clip_cnt is tied to 0 (clipping itself is unaffected).
//
// state | meaning
// RUN   | accepting pixels, pix_ready=1
// DRAIN | 2 cycles letting in-flight plot writes land before clearing
// CLEAR | writing 0 to one word per cycle from address 0 up; counters held at 0
module frame_buffer_writer #(
   parameter int FB_W = 160,
   parameter int FB_H = 120
) (
   input  logic                               clk,
   input  logic                               reset,
   frame_buffer_writer_if.slave               pix,
   input  logic                               clear_req,
   output logic                               busy,
   input  logic [$clog2(FB_W*FB_H/16)-1:0]    rd_addr,
   output logic [15:0]                        rd_data,
   output logic [15:0]                        plot_cnt,
   output logic [15:0]                        clip_cnt
);
   localparam int WORDS = FB_W * FB_H / 16;
   localparam int AW    = $clog2(WORDS);
   localparam int WPR   = FB_W / 16;

   localparam logic [8:0]    X_LIM     = 9'(FB_W);
   localparam logic [7:0]    Y_LIM     = 8'(FB_H);
   localparam logic [AW:0]   WORDS_L   = (AW+1)'(WORDS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

   typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

   state_t          state;
   logic            drain_cnt;
   logic [AW-1:0]   clr_addr;

   logic [15:0]     mem [WORDS];

   logic            accept;
   logic            in_range;
   logic [AW-1:0]   pix_addr;

   logic            s1_valid;
   logic [AW-1:0]   s1_addr;
   logic [3:0]      s1_bit;
   logic [15:0]     s1_word;
   logic            s2_valid;
   logic [AW-1:0]   s2_addr;
   logic [15:0]     s2_data;

   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [15:0]     mem_wdata;

   // pix_ready is registered, so it is still high in the cycle clear_req is
   // sampled; that pixel must not be taken.
   assign accept   = pix.pix_valid & pix.pix_ready & ~clear_req;
   // Sign bits checked first; once non-negative the unsigned compare is exact.
   assign in_range = ~pix.x_in[8] & (pix.x_in < X_LIM) &
                     ~pix.y_in[7] & (pix.y_in < Y_LIM);
   assign pix_addr = AW'(32'(pix.y_in[6:0]) * WPR) + AW'(pix.x_in[7:4]);

   // Stage 2 writes at the end of this cycle, so memory is stale for a
   // stage-1 read of the same word; take the in-flight value instead.
   assign s1_word = (s2_valid && (s2_addr == s1_addr)) ? s2_data : mem[s1_addr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= CLEAR;
         drain_cnt     <= 1'b0;
         clr_addr      <= '0;
         pix.pix_ready <= 1'b0;
         busy          <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (clear_req) begin
                  state         <= DRAIN;
                  drain_cnt     <= 1'b1;
                  pix.pix_ready <= 1'b0;
                  busy          <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == 1'b0) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            CLEAR: begin
               if (clr_addr == LAST_ADDR) begin
                  state         <= RUN;
                  pix.pix_ready <= 1'b1;
                  busy          <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + AW'(1);
               end
            end
            default: begin
               state         <= CLEAR;
               clr_addr      <= '0;
               pix.pix_ready <= 1'b0;
               busy          <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_bit   <= '0;
         s2_valid <= 1'b0;
         s2_addr  <= '0;
         s2_data  <= '0;
         plot_cnt <= '0;
      end else begin
         s1_valid <= accept & in_range;
         s1_addr  <= pix_addr;
         s1_bit   <= pix.x_in[3:0];
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
         s2_data  <= s1_word | (16'h0001 << s1_bit);
         if (state == CLEAR)
            plot_cnt <= '0;
         else if (accept && in_range && plot_cnt != 16'hFFFF)
            plot_cnt <= plot_cnt + 16'd1;
      end
   end

`ifdef FB_CLIP_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         clip_cnt <= '0;
      else if (state == CLEAR)
         clip_cnt <= '0;
      else if (accept && !in_range && clip_cnt != 16'hFFFF)
         clip_cnt <= clip_cnt + 16'd1;
   end
`else
   assign clip_cnt = '0;
`endif

   // The pipeline is always empty in CLEAR, so the two writers never collide.
   always_comb begin
      mem_we    = s2_valid;
      mem_waddr = s2_addr;
      mem_wdata = s2_data;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_wdata = '0;
      end
   end

   // Contents are deliberately not reset; the post-reset CLEAR pass does it.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_data <= '0;
      else if ({1'b0, rd_addr} < WORDS_L)
         rd_data <= mem[rd_addr];
   end
endmodule

// File: tb/tb_frame_buffer_writer.sv
module tb_frame_buffer_writer;
   localparam int W = 160;
   localparam int H = 120;
   localparam int NW = W * H / 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear_req;
   logic        busy;
   logic [10:0] rd_addr;
   logic [15:0] rd_data;
   logic [15:0] plot_cnt;
   logic [15:0] clip_cnt;

   frame_buffer_writer_if pix_if ();

   frame_buffer_writer #(.FB_W(W), .FB_H(H)) dut (
      .clk       (clk),
      .reset     (reset),
      .pix       (pix_if),
      .clear_req (clear_req),
      .busy      (busy),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .plot_cnt  (plot_cnt),
      .clip_cnt  (clip_cnt)
   );

   always #5 clk = ~clk;

   logic [15:0] m_mem [NW];
   int m_plot;
   int m_clip;
   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NW; i++) m_mem[i] = 16'h0000;
      m_plot = 0;
      m_clip = 0;
   endtask

   task automatic model_pix(input int x, input int y);
      if (x < 0 || x >= W || y < 0 || y >= H) begin
         if (m_clip < 65535) m_clip++;
      end else begin
         m_mem[y * (W / 16) + x / 16] |= (16'h0001 << (x % 16));
         if (m_plot < 65535) m_plot++;
      end
   endtask

   function automatic int exp_clip();
`ifdef FB_CLIP_COUNT_EN
      return m_clip;
`else
      return 0;
`endif
   endfunction

   // Leaves pix_valid high so consecutive calls form back-to-back pixels.
   task automatic send(input int x, input int y);
      int guard;
      guard = 0;
      pix_if.pix_valid = 1'b1;
      pix_if.x_in = 9'(x);
      pix_if.y_in = 8'(y);
      while (pix_if.pix_ready !== 1'b1 && guard < 3000) begin
         guard++;
         tick();
      end
      if (guard >= 3000) check("send_ready_timeout", guard, 0);
      tick();
      model_pix(x, y);
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < NW; a++) begin
         rd_addr = 11'(a);
         tick();
         check(tag, rd_data, m_mem[a]);
      end
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      int low;
      int x;
      int y;
      int w;
      logic acc;

      reset = 1'b0;
      clear_req = 1'b0;
      rd_addr = '0;
      pix_if.pix_valid = 1'b0;
      pix_if.x_in = '0;
      pix_if.y_in = '0;
      model_clear();
      repeat (3) tick();

      check("rst_busy", busy, 1);
      check("rst_pix_ready", pix_if.pix_ready, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_plot_cnt", plot_cnt, 0);
      check("rst_clip_cnt", clip_cnt, 0);

      reset = 1'b1;
      wait_busy(n);
      check("post_reset_clear_len", n, 1200);
      check("post_reset_ready", pix_if.pix_ready, 1);
      sweep("post_reset_zero");

      // Single plot (17,2) -> word 21 bit 1; same-cycle read sees the old word.
      send(17, 2);
      pix_if.pix_valid = 1'b0;
      tick();
      rd_addr = 11'd21;
      tick();
      check("rd_during_write_old", rd_data, 16'h0000);
      tick();
      check("single_plot_word21", rd_data, m_mem[21]);
      check("single_plot_value", rd_data, 16'h0002);
      check("single_plot_cnt", plot_cnt, 1);

      rd_addr = 11'd1500;
      tick();
      check("oor_addr_hold", rd_data, 16'h0002);
      rd_addr = 11'd2047;
      tick();
      check("oor_addr_hold_max", rd_data, 16'h0002);

      // Clear mid-stream: pix_valid held, clear_req pulsed at step 12.
      w = 0;
      pix_if.pix_valid = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         x = int'($urandom_range(0, W - 1));
         y = int'($urandom_range(0, H - 1));
         pix_if.x_in = 9'(x);
         pix_if.y_in = 8'(y);
         clear_req = (k == 12);
         acc = (pix_if.pix_ready === 1'b1) && !clear_req;
         if (acc) w = y * (W / 16) + x / 16;
         tick();
         if (acc) model_pix(x, y);
         clear_req = 1'b0;
      end
      check("no_accept_on_clear_cycle", plot_cnt, m_plot);
      rd_addr = 11'(w);
      low = 0;
      while (pix_if.pix_ready === 1'b0 && low < 3000) begin
         low++;
         tick();
         if (low == 2) check("drain_last_pixel_written", rd_data, m_mem[w]);
      end
      pix_if.pix_valid = 1'b0;
      check("clear_ready_low_len", low, 1202);
      model_clear();
      check("clear_plot_cnt", plot_cnt, 0);
      check("clear_clip_cnt", clip_cnt, 0);
      sweep("after_clear_zero");

      // Same word back to back.
      send(0, 0);
      send(1, 0);
      send(15, 0);
      pix_if.pix_valid = 1'b0;
      repeat (3) tick();
      rd_addr = 11'd0;
      tick();
      check("same_word_value", rd_data, 16'h8003);
      check("same_word_cnt", plot_cnt, 3);

      // Clipping.
      send(-1, 5);
      send(160, 5);
      send(5, -3);
      send(5, 120);
      pix_if.pix_valid = 1'b0;
      repeat (3) tick();
      check("clip_plot_cnt", plot_cnt, 3);
      check("clip_clip_cnt", clip_cnt, exp_clip());
      sweep("clip_no_mem_change");

      // Re-plot of a set pixel still counts; then a random mix.
      send(1, 0);
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            send(int'($urandom_range(0, 199)) - 20, int'($urandom_range(0, 137)) - 10);
         end else begin
            pix_if.pix_valid = 1'b0;
            tick();
         end
      end
      pix_if.pix_valid = 1'b0;
      repeat (3) tick();
      check("random_plot_cnt", plot_cnt, m_plot);
      check("random_clip_cnt", clip_cnt, exp_clip());
      sweep("random_mem");

      // Reset in the middle of a clear.
      send(100, 115);
      pix_if.pix_valid = 1'b0;
      repeat (3) tick();
      rd_addr = 11'd1156;
      tick();
      check("pre_clear_word1156", rd_data, m_mem[1156]);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (2 + 500) tick();
      check("mid_clear_busy", busy, 1);
      check("mid_clear_word1156", rd_data, m_mem[1156]);
      reset = 1'b0;
      #1;
      check("async_rst_busy", busy, 1);
      check("async_rst_ready", pix_if.pix_ready, 0);
      check("async_rst_rd_data", rd_data, 0);
      check("async_rst_plot_cnt", plot_cnt, 0);
      check("async_rst_clip_cnt", clip_cnt, 0);
      tick();
      reset = 1'b1;
      wait_busy(n);
      check("restart_clear_len", n, 1200);
      check("restart_ready", pix_if.pix_ready, 1);
      model_clear();
      sweep("restart_zero");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
